sevenseg_scan: RTL and testbench

Time-multiplexed scan driver for a common-anode 8-digit seven-segment display. Consumes the packed, already-decoded active-low segment vector from the seven-segment MMIO register bank. Drives one digit's anode and cathodes at a time at a fixed per-digit dwell. Sits between the register bank and the board's anode/cathode pins.

---
 rtl/sevenseg_scan_if.sv | 21 ++
 rtl/sevenseg_scan.sv | 94 +++++++++
 tb/tb_sevenseg_scan.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_if.sv
// Register-bank to scan-driver bundle: decoded segment patterns and enables in,
// anode/cathode pins and frame tick out.
interface sevenseg_scan_if #(
   parameter int DIGITS = 8
);
   logic [7*DIGITS-1:0] sevenseg;
   logic [DIGITS-1:0]   digit_en;
   logic [6:0]          seg_n;
   logic [DIGITS-1:0]   an_n;
   logic                frame_tick;

   modport master (
      output sevenseg, digit_en,
      input  seg_n, an_n, frame_tick
   );

   modport slave (
      input  sevenseg, digit_en,
      output seg_n, an_n, frame_tick
   );
endinterface

// File: rtl/sevenseg_scan.sv
// Common-anode seven-segment scan driver; outputs lag (idx, cnt, inputs) by 1 clk, never stalls.
// Define SEVENSEG_SCAN_BLANK_EN to blank the first BLANK_CLKS cycles of each slot (anti-ghosting).
module sevenseg_scan #(
   parameter int DIGITS         = 8,
   parameter int CLKS_PER_DIGIT = 50000,
   parameter int BLANK_CLKS     = 500
) (
   input  logic           clk,
   input  logic           rst_n,
   sevenseg_scan_if.slave scan_if
);
   localparam int CW = $clog2(CLKS_PER_DIGIT);
   localparam int IW = $clog2(DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_DIGIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   if (DIGITS < 2 || CLKS_PER_DIGIT < 2) begin : g_bad_size
      $error("sevenseg_scan: DIGITS and CLKS_PER_DIGIT must be >= 2");
   end

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              wrap_q, wrap_d;
   logic              tick_q, tick_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] onehot;
   logic              blank;

`ifdef SEVENSEG_SCAN_BLANK_EN
   localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CLKS);

   if (BLANK_CLKS < 1 || BLANK_CLKS >= CLKS_PER_DIGIT) begin : g_bad_blank
      $error("sevenseg_scan: BLANK_CLKS must lie in 1..CLKS_PER_DIGIT-1");
   end

   assign blank = (cnt_q < BLANK_CNT);
`else
   if (BLANK_CLKS < 0) begin : g_bad_blank
      $error("sevenseg_scan: BLANK_CLKS must not be negative");
   end

   assign blank = 1'b0;
`endif

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      idx_d  = idx_q;
      wrap_d = 1'b0;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            wrap_d = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      // The tick lands one cycle after the wrap so it lines up with digit 0 on the pins.
      tick_d = wrap_q;

      onehot        = '0;
      onehot[idx_q] = 1'b1;
      an_d          = '1;
      seg_d         = 7'h7F;
      if (!blank && scan_if.digit_en[idx_q]) begin
         an_d  = ~onehot;
         seg_d = scan_if.sevenseg[7*idx_q +: 7];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         wrap_q <= 1'b0;
         tick_q <= 1'b0;
         an_q   <= '1;
         seg_q  <= 7'h7F;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         wrap_q <= wrap_d;
         tick_q <= tick_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign scan_if.an_n       = an_q;
   assign scan_if.seg_n      = seg_q;
   assign scan_if.frame_tick = tick_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomized bench for sevenseg_scan: reference model derives the lit digit from elapsed cycles.
module tb_sevenseg_scan;
   localparam int D = 8;
   localparam int C = 4;
   localparam int B = 1;
`ifdef SEVENSEG_SCAN_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sevenseg_scan_if #(.DIGITS(D)) bus ();

   sevenseg_scan #(
      .DIGITS         (D),
      .CLKS_PER_DIGIT (C),
      .BLANK_CLKS     (B)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scan_if (bus)
   );

   logic [6:0]   pat [D];
   logic [D-1:0] en;
   int n_run  = 0;
   int n_fail = 0;
   int k      = 0;
   int ticks  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, k);
      end
   endtask

   task automatic drive();
      logic [7*D-1:0] v;
      for (int i = 0; i < D; i++) v[7*i +: 7] = pat[i];
      bus.sevenseg = v;
      bus.digit_en = en;
   endtask

   // k counts clock edges since reset release; edge k displays slot k/C of the scan.
   task automatic step();
      int cyc, dig, ph;
      logic lit;
      logic [D-1:0] exp_an;
      logic [6:0] exp_seg;
      logic exp_ft;
      @(posedge clk);
      cyc = k;
      k++;
      dig = (cyc / C) % D;
      ph  = cyc % C;
      lit = en[dig] && !(BLANK_ON && ph < B);
      exp_an  = lit ? ~(D'(1) << dig) : '1;
      exp_seg = lit ? pat[dig] : 7'h7F;
      exp_ft  = (cyc > 0) && (cyc % (C * D) == 0);
      #1;
      check_eq("an_n", bus.an_n, exp_an);
      check_eq("seg_n", bus.seg_n, exp_seg);
      check_eq("frame_tick", bus.frame_tick, exp_ft);
      check_eq("an_onehot", ($countones(~bus.an_n) <= 1), 1);
      if (bus.frame_tick) ticks++;
   endtask

   initial begin
      for (int i = 0; i < D; i++) pat[i] = 7'h40 + 7'(i);
      en = '1;
      drive();

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_an_n", bus.an_n, 8'hFF);
      check_eq("rst_seg_n", bus.seg_n, 7'h7F);
      check_eq("rst_frame_tick", bus.frame_tick, 0);

      rst_n = 1'b1;
      k     = 0;
      ticks = 0;
      repeat (66) step();
      check_eq("tick_count", ticks, 2);

      en = 8'b1111_0101;
      drive();
      repeat (32) step();

      en = '1;
      drive();
      for (int g = 0; g < 64 && !(((k / C) % D) == 2 && (k % C) == 1); g++) step();
      pat[2] = 7'h24;
      drive();
      step();
      check_eq("live_seg", bus.seg_n, 7'h24);
      check_eq("live_an", bus.an_n, 8'hFB);

      repeat (400) begin
         if ($urandom_range(3) == 0) pat[$urandom_range(D - 1)] = 7'($urandom);
         if ($urandom_range(15) == 0) en = D'($urandom);
         drive();
         step();
      end

      en = '1;
      drive();
      for (int g = 0; g < 64 && !(((k / C) % D) == 5 && (k % C) == 2); g++) step();
      rst_n = 1'b0;
      #1;
      check_eq("async_an_n", bus.an_n, 8'hFF);
      check_eq("async_seg_n", bus.seg_n, 7'h7F);
      check_eq("async_frame_tick", bus.frame_tick, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      k     = 0;
      repeat (40) step();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
